// File: rtl/arp_query_retry.sv
// Next-hop resolution front-end: classifies a destination, queries arp_cache,
// and drives who-has retries with a fixed back-off before answering the IP layer.
module arp_query_retry #(
    parameter int unsigned RETRY_COUNT    = 4,
    parameter int unsigned RETRY_INTERVAL = 250000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arp_request_valid,
    output logic        arp_request_ready,
    input  logic [31:0] arp_request_ip,
    output logic        arp_response_valid,
    input  logic        arp_response_ready,
    output logic        arp_response_error,
    output logic [47:0] arp_response_mac,
    output logic        cache_query_request_valid,
    input  logic        cache_query_request_ready,
    output logic [31:0] cache_query_request_ip,
    input  logic        cache_query_response_valid,
    output logic        cache_query_response_ready,
    input  logic        cache_query_response_error,
    input  logic [47:0] cache_query_response_mac,
    output logic        arp_tx_request_valid,
    input  logic        arp_tx_request_ready,
    output logic [31:0] arp_tx_request_ip,
    input  logic [31:0] local_ip,
    input  logic [31:0] gateway_ip,
    input  logic [31:0] subnet_mask,
    output logic        busy
);
    localparam int unsigned   CW         = (RETRY_COUNT > 0) ? $clog2(RETRY_COUNT + 1) : 1;
    localparam logic [CW-1:0] RETRY_LOAD = CW'(RETRY_COUNT);
    localparam logic [31:0]   TIMER_LOAD = 32'(RETRY_INTERVAL - 1);

    typedef enum logic [2:0] {IDLE, QUERY, WAIT_CACHE, SEND_REQ, WAIT_RETRY, RESPOND} state_t;
    state_t state, state_nxt;

    logic [CW-1:0] retry_cnt;
    logic [31:0]   timer;
    logic [31:0]   target_ip;
    logic          req_hs, cq_req_hs, cq_rsp_hs, tx_hs, rsp_hs;
    logic          is_local, is_bcast, no_gw;

    // Handshakes are decoded from state so they do not loop through the output logic
    assign req_hs    = (state == IDLE) & arp_request_ready & arp_request_valid;
    assign cq_req_hs = (state == QUERY) & cache_query_request_ready;
    assign cq_rsp_hs = (state == WAIT_CACHE) & cache_query_response_valid;
    assign tx_hs     = (state == SEND_REQ) & arp_tx_request_ready;
    assign rsp_hs    = (state == RESPOND) & arp_response_ready;

    assign is_local = (arp_request_ip & subnet_mask) == (local_ip & subnet_mask);
    assign is_bcast = (arp_request_ip == '1) ||
                      (((arp_request_ip & ~subnet_mask) == ~subnet_mask) && is_local);
    assign no_gw    = !is_local && (gateway_ip == 32'd0);

    assign cache_query_request_ip = target_ip;
    assign arp_tx_request_ip      = target_ip;

    always_comb begin
        state_nxt                  = state;
        cache_query_request_valid  = 1'b0;
        cache_query_response_ready = 1'b0;
        arp_tx_request_valid       = 1'b0;
        arp_response_valid         = 1'b0;
        busy                       = (state != IDLE);
        case (state)
            IDLE: begin
                if (req_hs) state_nxt = (is_bcast || no_gw) ? RESPOND : QUERY;
            end
            QUERY: begin
                cache_query_request_valid = 1'b1;
                if (cq_req_hs) state_nxt = WAIT_CACHE;
            end
            WAIT_CACHE: begin
                cache_query_response_ready = 1'b1;
                if (cq_rsp_hs)
                    state_nxt = (!cache_query_response_error || retry_cnt == '0) ? RESPOND : SEND_REQ;
            end
            SEND_REQ: begin
                arp_tx_request_valid = 1'b1;
                if (tx_hs) state_nxt = WAIT_RETRY;
            end
            WAIT_RETRY: begin
                if (timer == '0) state_nxt = QUERY;
            end
            RESPOND: begin
                arp_response_valid = 1'b1;
                if (rsp_hs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            arp_request_ready  <= 1'b0;
            target_ip          <= '0;
            retry_cnt          <= '0;
            timer              <= '0;
            arp_response_mac   <= '0;
            arp_response_error <= 1'b0;
        end else begin
            state             <= state_nxt;
            arp_request_ready <= (state_nxt == IDLE);
            case (state)
                IDLE: if (req_hs) begin
                    retry_cnt <= RETRY_LOAD;
                    target_ip <= is_local ? arp_request_ip : gateway_ip;
                    if (is_bcast) begin
                        arp_response_mac   <= '1;
                        arp_response_error <= 1'b0;
                    end else if (no_gw) begin
                        arp_response_mac   <= '0;
                        arp_response_error <= 1'b1;
                    end
                end
                WAIT_CACHE: if (cq_rsp_hs) begin
                    if (!cache_query_response_error) begin
                        arp_response_mac   <= cache_query_response_mac;
                        arp_response_error <= 1'b0;
                    end else if (retry_cnt == '0) begin
                        arp_response_mac   <= '0;
                        arp_response_error <= 1'b1;
                    end
                end
                SEND_REQ: if (tx_hs) begin
                    retry_cnt <= retry_cnt - 1'b1;
                    timer     <= TIMER_LOAD;
                end
                WAIT_RETRY: if (timer != '0) timer <= timer - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_arp_query_retry.sv
// Randomized bench for arp_query_retry: cycle-stepped cache/tx/IP-layer models
// checked against an outcome model derived from the resolution rules.
module tb_arp_query_retry;
    localparam int RC = 2;
    localparam int RI = 10;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        arp_request_valid, arp_request_ready;
    logic [31:0] arp_request_ip;
    logic        arp_response_valid, arp_response_ready, arp_response_error;
    logic [47:0] arp_response_mac;
    logic        cache_query_request_valid, cache_query_request_ready;
    logic [31:0] cache_query_request_ip;
    logic        cache_query_response_valid, cache_query_response_ready, cache_query_response_error;
    logic [47:0] cache_query_response_mac;
    logic        arp_tx_request_valid, arp_tx_request_ready;
    logic [31:0] arp_tx_request_ip;
    logic [31:0] local_ip, gateway_ip, subnet_mask;
    logic        busy;

    logic [31:0] cfg_local, cfg_gw, cfg_mask;
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    arp_query_retry #(.RETRY_COUNT(RC), .RETRY_INTERVAL(RI)) dut (
        .clk(clk), .rst_n(rst_n),
        .arp_request_valid(arp_request_valid), .arp_request_ready(arp_request_ready),
        .arp_request_ip(arp_request_ip),
        .arp_response_valid(arp_response_valid), .arp_response_ready(arp_response_ready),
        .arp_response_error(arp_response_error), .arp_response_mac(arp_response_mac),
        .cache_query_request_valid(cache_query_request_valid),
        .cache_query_request_ready(cache_query_request_ready),
        .cache_query_request_ip(cache_query_request_ip),
        .cache_query_response_valid(cache_query_response_valid),
        .cache_query_response_ready(cache_query_response_ready),
        .cache_query_response_error(cache_query_response_error),
        .cache_query_response_mac(cache_query_response_mac),
        .arp_tx_request_valid(arp_tx_request_valid), .arp_tx_request_ready(arp_tx_request_ready),
        .arp_tx_request_ip(arp_tx_request_ip),
        .local_ip(local_ip), .gateway_ip(gateway_ip), .subnet_mask(subnet_mask),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outcome of one request: direct answer or target + query/tx counts
    task automatic model(input logic [31:0] ip, input int misses, input logic [47:0] cmac,
                         output bit direct, output logic [31:0] tgt, output int nq, output int ntx,
                         output logic [47:0] emac, output bit eerr);
        bit same;
        same   = ((ip ^ cfg_local) & cfg_mask) == 32'd0;
        direct = 1'b0; tgt = 32'd0; nq = 0; ntx = 0;
        if (ip == 32'hFFFF_FFFF || (same && (ip | cfg_mask) == 32'hFFFF_FFFF)) begin
            direct = 1'b1; emac = 48'hFFFF_FFFF_FFFF; eerr = 1'b0;
        end else if (!same && cfg_gw == 32'd0) begin
            direct = 1'b1; emac = 48'd0; eerr = 1'b1;
        end else begin
            tgt  = same ? ip : cfg_gw;
            ntx  = (misses < RC) ? misses : RC;
            nq   = ntx + 1;
            eerr = (misses > RC);
            emac = eerr ? 48'd0 : cmac;
        end
    endtask

    task automatic idle_inputs();
        arp_request_valid = 0; arp_request_ip = 0; arp_response_ready = 0;
        cache_query_request_ready = 0; cache_query_response_valid = 0;
        cache_query_response_error = 0; cache_query_response_mac = 0; arp_tx_request_ready = 0;
        local_ip = cfg_local; gateway_ip = cfg_gw; subnet_mask = cfg_mask;
    endtask

    task automatic do_req(input logic [31:0] ip, input int misses, input logic [47:0] cmac,
                          input bit bp, input bit abort);
        bit          direct, eerr, done, pend, perr, accepted, prev_cq, prev_rv, prev_rr, aborted;
        logic [31:0] tgt;
        logic [47:0] emac, prev_mac;
        int          nq, ntx, t, acc, tx_edge, q_cnt, tx_cnt, hold, dly;
        model(ip, misses, cmac, direct, tgt, nq, ntx, emac, eerr);
        idle_inputs();
        arp_request_valid = 1; arp_request_ip = ip;
        t = 0; acc = -1; tx_edge = -1; q_cnt = 0; tx_cnt = 0; hold = 0; dly = 0;
        done = 0; pend = 0; perr = 0; accepted = 0; aborted = 0;
        prev_cq = 0; prev_rv = 0; prev_rr = 0; prev_mac = 0;
        while (!done && t < 400) begin
            @(negedge clk); t++;
            if (acc >= 0 && t == acc + 1) begin
                if (direct) chk("rsp_latency", arp_response_valid, 1);
                else        chk("query_latency", cache_query_request_valid, 1);
            end
            if (accepted) chk("ready_while_busy", arp_request_ready, 0);
            if (cache_query_request_valid && !prev_cq) begin
                chk("query_ip", cache_query_request_ip, tgt);
                if (tx_edge >= 0) chk("retry_gap", t - tx_edge, RI + 1);
            end
            if (prev_rv && !prev_rr) begin
                chk("rsp_hold_valid", arp_response_valid, 1);
                chk("rsp_hold_mac", arp_response_mac, prev_mac);
            end
            // drive inputs for the coming edge
            cache_query_request_ready = ($urandom_range(0, 3) != 0);
            arp_tx_request_ready      = ($urandom_range(0, 2) != 0);
            if (arp_response_valid && bp && hold < 20) begin
                arp_response_ready = 0; hold++;
            end else arp_response_ready = ($urandom_range(0, 3) != 0);
            cache_query_response_valid = pend && dly == 0;
            cache_query_response_error = perr;
            cache_query_response_mac   = perr ? 48'($urandom) : cmac;
            if (accepted) begin
                // ignored while busy; config must already be latched
                arp_request_valid = 1'($urandom_range(0, 1));
                arp_request_ip = $urandom; local_ip = $urandom;
                gateway_ip = $urandom; subnet_mask = $urandom;
            end
            if (!accepted && arp_request_valid && arp_request_ready) begin
                accepted = 1; acc = t;
            end
            if (cache_query_response_valid && cache_query_response_ready) pend = 0;
            else if (pend && dly > 0) dly--;
            if (cache_query_request_valid && cache_query_request_ready) begin
                q_cnt++; pend = 1; dly = $urandom_range(0, 2); perr = (q_cnt <= misses);
            end
            if (arp_tx_request_valid && arp_tx_request_ready) begin
                tx_cnt++; tx_edge = t;
                chk("tx_ip", arp_tx_request_ip, tgt);
            end
            if (arp_response_valid && arp_response_ready) begin
                chk("rsp_mac", arp_response_mac, emac);
                chk("rsp_error", arp_response_error, eerr);
                done = 1;
            end
            prev_cq = cache_query_request_valid; prev_rv = arp_response_valid;
            prev_rr = arp_response_ready;       prev_mac = arp_response_mac;
            if (abort && tx_edge >= 0 && t == tx_edge + 4) begin
                #2 rst_n = 0;
                #1;
                chk("abort_query_valid", cache_query_request_valid, 0);
                chk("abort_tx_valid", arp_tx_request_valid, 0);
                chk("abort_rsp_valid", arp_response_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_ready", arp_request_ready, 0);
                done = 1; aborted = 1;
            end
        end
        if (!done) chk("timeout", 0, 1);
        if (!aborted) begin
            chk("query_count", q_cnt, nq);
            chk("tx_count", tx_cnt, ntx);
            @(negedge clk);
            idle_inputs();
            chk("ready_after_rsp", arp_request_ready, 1);
            chk("idle_after_rsp", busy, 0);
        end else idle_inputs();
    endtask

    initial begin
        logic [63:0] rnd;
        logic [31:0] ip;
        int          sel;
        cfg_local = 32'hC0A8_010A; cfg_gw = 32'hC0A8_0101; cfg_mask = 32'hFFFF_FF00;
        idle_inputs();
        repeat (3) @(negedge clk);
        chk("rst_req_ready", arp_request_ready, 0);
        chk("rst_rsp_valid", arp_response_valid, 0);
        chk("rst_query_valid", cache_query_request_valid, 0);
        chk("rst_tx_valid", arp_tx_request_valid, 0);
        chk("rst_cache_ready", cache_query_response_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_mac", arp_response_mac, 0);
        chk("rst_rsp_error", arp_response_error, 0);
        chk("rst_query_ip", cache_query_request_ip, 0);
        chk("rst_tx_ip", arp_tx_request_ip, 0);
        rst_n = 1;
        @(negedge clk);
        chk("ready_first_edge", arp_request_ready, 1);

        do_req(32'hC0A8_0114, 0, 48'h0200_0000_0001, 0, 0);   // hit
        do_req(32'hC0A8_01FF, 0, 48'h0, 0, 0);                // subnet broadcast
        do_req(32'hFFFF_FFFF, 0, 48'h0, 0, 0);                // limited broadcast
        do_req(32'h0808_0808, 0, 48'h0200_0000_0002, 0, 0);   // via gateway
        cfg_gw = 32'd0;
        do_req(32'h0808_0808, 0, 48'h0, 0, 0);                // no gateway
        cfg_gw = 32'hC0A8_0101;
        do_req(32'hC0A8_0120, RC + 1, 48'h0200_0000_0003, 0, 0); // exhausted
        do_req(32'hC0A8_0121, 1, 48'h0200_0000_0004, 0, 0);      // late hit
        do_req(32'hC0A8_0122, 0, 48'h0200_0000_0005, 1, 0);      // response backpressure

        do_req(32'hC0A8_0123, RC + 1, 48'h0, 0, 1);               // reset in WAIT_RETRY
        repeat (2) @(negedge clk);
        chk("in_reset_busy", busy, 0);
        rst_n = 1;
        @(negedge clk);
        chk("ready_after_abort", arp_request_ready, 1);
        do_req(32'hC0A8_0124, 0, 48'h0200_0000_0006, 0, 0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: cfg_mask = 32'hFFFF_FF00;
                1: cfg_mask = 32'hFFFF_0000;
                default: cfg_mask = 32'hFFFF_FFFC;
            endcase
            cfg_local = $urandom;
            cfg_gw    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            sel = $urandom_range(0, 5);
            case (sel)
                0: ip = 32'hFFFF_FFFF;
                1: ip = (cfg_local & cfg_mask) | ~cfg_mask;
                2, 3: ip = (cfg_local & cfg_mask) | ($urandom & ~cfg_mask);
                default: ip = $urandom;
            endcase
            rnd = {$urandom, $urandom};
            do_req(ip, $urandom_range(0, RC + 1), rnd[47:0], (i % 7) == 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
